// File: rtl/ysyx_22050710_mem_pkg.sv
// Shared types and constants for the NPC data-memory responder.
package ysyx_22050710_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  localparam logic [63:0] DEF_BASE    = 64'h8000_0000;
  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned LAT_MIN     = 1;
  localparam int unsigned LAT_MAX     = 15;
  localparam int unsigned CNT_W       = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/ysyx_22050710_lane_align.sv
// Byte-lane alignment: read word shifted down to the access offset, write data/mask shifted up.
module ysyx_22050710_lane_align (
  input  logic [2:0]  off_i,
  input  logic [63:0] rd_word_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  output logic [63:0] rd_data_o,
  output logic [63:0] wr_data_o,
  output logic [7:0]  wr_mask_o
);

  // Lanes shifted past byte 7 are dropped: an access never spills into the next word.
  assign rd_data_o = rd_word_i >> {off_i, 3'b000};
  assign wr_data_o = wdata_i << {off_i, 3'b000};
  assign wr_mask_o = wmask_i << off_i;

endmodule

// File: rtl/ysyx_22050710_memresp.sv
// Data-memory target: one outstanding request, fixed access latency, held response.
module ysyx_22050710_memresp
  import ysyx_22050710_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = DEF_LATENCY,
  parameter logic [63:0] BASE        = DEF_BASE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_wdata,
  input  logic [7:0]  i_req_wmask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned LAT_EFF  = (LATENCY < LAT_MIN) ? LAT_MIN :
                                     (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_EFF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, wdata_q;
  logic             wen_q;
  logic [7:0]       wmask_q;
  logic [63:0]      rdata_q;
  logic             err_q;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic        accept;
  logic        acc_now;
  logic [63:0] acc_addr, acc_wdata, acc_off;
  logic        acc_wen, acc_err;
  logic [7:0]  acc_wmask;
  logic [AW-1:0] acc_idx;
  logic [63:0] rd_aligned, wr_data;
  logic [7:0]  wr_mask;
  logic        mem_we;

  assign accept = (state_q == S_IDLE) && i_req_valid;

  // With a one-cycle latency the access happens on the accepting edge, straight from the inputs.
  assign acc_now   = (accept && (LAT_EFF == 1)) ||
                     ((state_q == S_BUSY) && (cnt_q == '0));
  assign acc_addr  = (state_q == S_IDLE) ? i_req_addr  : addr_q;
  assign acc_wen   = (state_q == S_IDLE) ? i_req_wen   : wen_q;
  assign acc_wdata = (state_q == S_IDLE) ? i_req_wdata : wdata_q;
  assign acc_wmask = (state_q == S_IDLE) ? i_req_wmask : wmask_q;

  assign acc_off = acc_addr - BASE;
  assign acc_err = (acc_addr < BASE) || (acc_off >= SPAN);
  assign acc_idx = acc_off[3 +: AW];
  assign mem_we  = acc_now && acc_wen && !acc_err && i_rst_n;

  ysyx_22050710_lane_align u_align (
    .off_i     (acc_addr[2:0]),
    .rd_word_i (mem_q[acc_idx]),
    .wdata_i   (acc_wdata),
    .wmask_i   (acc_wmask),
    .rd_data_o (rd_aligned),
    .wr_data_o (wr_data),
    .wr_mask_o (wr_mask)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          cnt_d   = CNT_INIT;
          state_d = (LAT_EFF == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= i_req_addr;
        wen_q   <= i_req_wen;
        wdata_q <= i_req_wdata;
        wmask_q <= i_req_wmask;
      end
      if (acc_now) begin
        rdata_q <= (acc_wen || acc_err) ? 64'd0 : rd_aligned;
        err_q   <= acc_err;
      end else if ((state_q == S_RESP) && i_rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem_q[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22050710_memresp.sv
// Directed bench for the data-memory responder, built with a three-cycle latency.
module tb_ysyx_22050710_memresp;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ysyx_22050710_memresp #(
    .DEPTH_WORDS (256),
    .LATENCY     (LAT),
    .BASE        (64'h8000_0000)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_wen   (req_wen),
    .i_req_wdata (req_wdata),
    .i_req_wmask (req_wmask),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  // Issue one request (called just after a rising edge), scramble the inputs after
  // acceptance, wait for the response, record it, then hand-shake it away.
  task automatic xact(input logic [63:0] a, input logic w, input logic [63:0] d,
                      input logic [7:0] m, output logic [63:0] rd, output logic e,
                      output int lat);
    int n;
    req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~a; req_wen = ~w; req_wdata = ~d; req_wmask = ~m;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      tests_run++; tests_failed++;
      $display("FAIL rsp_timeout addr=%h: no response within %0d cycles", a, n);
    end
    lat = n; rd = rsp_rdata; e = rsp_err;
    $display("[TB] txn addr=%h wen=%0d wdata=%h wmask=%h -> rdata=%h err=%0d lat=%0d",
             a, w, d, m, rd, e, lat);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
    tests_run++;
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%0b exp=0", rsp_valid); end
    tests_run++;
    if (rsp_rdata !== 64'd0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    tests_run++;
    if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
  endtask

  task automatic test_full_word();
    logic [63:0] rd; logic e; int lat;
    xact(64'h8000_0000, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, rd, e, lat);
    tests_run++;
    if (rd !== 64'd0 || e !== 1'b0) begin tests_failed++; $display("FAIL wr_rsp got rdata=%h err=%0b exp rdata=0 err=0", rd, e); end
    tests_run++;
    if (lat !== LAT) begin tests_failed++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
    xact(64'h8000_0000, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'h1122_3344_5566_7788) begin tests_failed++; $display("FAIL rd_word got=%h exp=1122334455667788", rd); end
    tests_run++;
    if (e !== 1'b0) begin tests_failed++; $display("FAIL rd_word_err got=%0b exp=0", e); end
    tests_run++;
    if (lat !== LAT) begin tests_failed++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_byte_store();
    logic [63:0] rd; logic e; int lat;
    xact(64'h8000_0003, 1'b1, 64'h0000_0000_0000_00AB, 8'h01, rd, e, lat);
    xact(64'h8000_0000, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'h1122_3344_AB66_7788) begin tests_failed++; $display("FAIL byte_word got=%h exp=11223344ab667788", rd); end
    xact(64'h8000_0003, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'h0000_0011_2233_44AB) begin tests_failed++; $display("FAIL byte_offset_rd got=%h exp=00000011223344ab", rd); end
  endtask

  task automatic test_halfword_edge();
    logic [63:0] rd; logic e; int lat;
    xact(64'h8000_0008, 1'b1, 64'h0102_0304_0506_0708, 8'hFF, rd, e, lat);
    xact(64'h8000_0007, 1'b1, 64'h0000_0000_0000_BEEF, 8'h03, rd, e, lat);
    xact(64'h8000_0000, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'hEF22_3344_AB66_7788) begin tests_failed++; $display("FAIL half_lane7 got=%h exp=ef223344ab667788", rd); end
    xact(64'h8000_0008, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'h0102_0304_0506_0708) begin tests_failed++; $display("FAIL half_nowrap got=%h exp=0102030405060708", rd); end
  endtask

  task automatic test_range();
    logic [63:0] rd; logic e; int lat;
    xact(64'h7FFF_FFF8, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (e !== 1'b1 || rd !== 64'd0) begin tests_failed++; $display("FAIL below_base got rdata=%h err=%0b exp rdata=0 err=1", rd, e); end
    xact(64'h8000_0800, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, rd, e, lat);
    tests_run++;
    if (e !== 1'b1 || rd !== 64'd0) begin tests_failed++; $display("FAIL above_top got rdata=%h err=%0b exp rdata=0 err=1", rd, e); end
    xact(64'h8000_07F8, 1'b1, 64'hA5A5_0000_1234_5678, 8'hFF, rd, e, lat);
    xact(64'h8000_07F8, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (e !== 1'b0 || rd !== 64'hA5A5_0000_1234_5678) begin tests_failed++; $display("FAIL last_word got rdata=%h err=%0b exp rdata=a5a5000012345678 err=0", rd, e); end
    xact(64'h8000_0000, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'hEF22_3344_AB66_7788) begin tests_failed++; $display("FAIL err_no_write got=%h exp=ef223344ab667788", rd); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; int n;
    req_valid = 1'b1; req_addr = 64'h8000_0008; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
    @(posedge clk); #1;
    req_addr = 64'h8000_0000;  // second request waits with valid held high
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (n !== LAT) begin tests_failed++; $display("FAIL bp_latency got=%0d exp=%0d", n, LAT); end
    rd = rsp_rdata;
    $display("[TB] txn addr=%h wen=0 -> rdata=%h err=%0d lat=%0d (held)", 64'h8000_0008, rd, rsp_err, n);
    tests_run++;
    if (rd !== 64'h0102_0304_0506_0708) begin tests_failed++; $display("FAIL bp_data got=%h exp=0102030405060708", rd); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 64'h0102_0304_0506_0708) begin
        tests_failed++;
        $display("FAIL bp_hold cycle=%0d got valid=%0b ready=%0b rdata=%h exp valid=1 ready=0 rdata=0102030405060708",
                 i, rsp_valid, req_ready, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_after_hs got ready=%0b valid=%0b exp ready=1 valid=0", req_ready, rsp_valid); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_second_accept got ready=%0b exp=0", req_ready); end
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    $display("[TB] txn addr=%h wen=0 -> rdata=%h err=%0d lat=%0d (queued)", 64'h8000_0000, rsp_rdata, rsp_err, n);
    tests_run++;
    if (n !== LAT || rsp_rdata !== 64'hEF22_3344_AB66_7788) begin
      tests_failed++; $display("FAIL bp_second_rsp got lat=%0d rdata=%h exp lat=%0d rdata=ef223344ab667788", n, rsp_rdata, LAT);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic e; int lat;
    req_valid = 1'b1; req_addr = 64'h8000_0000; req_wen = 1'b1;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset got ready=%0b valid=%0b rdata=%h err=%0b exp ready=1 valid=0 rdata=0 err=0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xact(64'h8000_0000, 1'b0, 64'h0, 8'h00, rd, e, lat);
    tests_run++;
    if (rd !== 64'hEF22_3344_AB66_7788) begin tests_failed++; $display("FAIL mid_reset_nowrite got=%h exp=ef223344ab667788", rd); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_full_word();
    test_byte_store();
    test_halfword_edge();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
